lsu_ctrl: RTL

- Load/store sequencer between the RV32I execute stage and the data-memory port.
- Accepts one access at a time, generates word-aligned address, byte enables and lane-replicated store data.
- Runs the request/grant/response handshake with memory, waiting as long as memory takes.
- Returns loads lane-selected and sign/zero extended per funct3. Flags misaligned, illegal and grant-timeout accesses.

---
 rtl/lsu_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// RV32I load/store sequencer: one access at a time. Response 3 cycles after accept with immediate gnt/rvalid, 1 cycle for errors.
// Backpressure: req_ready_o only in IDLE. Waits on mem_gnt_i up to GNT_TIMEOUT cycles, then waits on mem_rvalid_i without limit.
module lsu_ctrl #(
   parameter int GNT_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        rsp_valid_o,
   output logic        rsp_err_o,
   output logic [31:0] rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int CW = $clog2(GNT_TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic [1:0]    r_state;
   req_t          r_req;
   logic [CW-1:0] r_cnt;
   logic          r_err;
   logic [31:0]   r_rdata;

   logic          w_legal;
   logic [1:0]    w_off;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic [31:0]   w_lane;
   logic [31:0]   w_ldata;
   logic          w_in_req;
   logic          w_in_resp;

   // Legality is judged on the live inputs so an illegal access never reaches REQ.
   always_comb begin
      w_legal = 1'b0;
      if (we_i) begin
         case (funct3_i)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~addr_i[0];
            3'b010:  w_legal = (addr_i[1:0] == 2'b00);
            default: w_legal = 1'b0;
         endcase
      end else begin
         case (funct3_i)
            3'b000, 3'b100: w_legal = 1'b1;
            3'b001, 3'b101: w_legal = ~addr_i[0];
            3'b010:         w_legal = (addr_i[1:0] == 2'b00);
            default:        w_legal = 1'b0;
         endcase
      end
   end

   assign w_off = r_req.addr[1:0];

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = r_req.wdata;
      case (r_req.funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{r_req.wdata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << w_off;
            w_wdata = {2{r_req.wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = r_req.wdata;
         end
      endcase
   end

   assign w_lane = mem_rdata_i >> {w_off, 3'b000};

   always_comb begin
      w_ldata = '0;
      case (r_req.funct3)
         3'b000:  w_ldata = {{24{w_lane[7]}}, w_lane[7:0]};
         3'b001:  w_ldata = {{16{w_lane[15]}}, w_lane[15:0]};
         3'b010:  w_ldata = w_lane;
         3'b100:  w_ldata = {24'd0, w_lane[7:0]};
         3'b101:  w_ldata = {16'd0, w_lane[15:0]};
         default: w_ldata = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_req   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  r_req   <= {we_i, funct3_i, addr_i, wdata_i};
                  r_cnt   <= '0;
                  r_rdata <= '0;
                  r_err   <= ~w_legal;
                  r_state <= w_legal ? S_REQ : S_RESP;
               end
            end
            S_REQ: begin
               // A grant on the final allowed cycle still wins over the timeout.
               if (mem_gnt_i) begin
                  r_state <= S_WAIT;
               end else if (r_cnt == CW'(GNT_TIMEOUT - 1)) begin
                  r_err   <= 1'b1;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_WAIT: begin
               if (mem_rvalid_i) begin
                  r_rdata <= r_req.we ? 32'd0 : w_ldata;
                  r_state <= S_RESP;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_err   <= 1'b0;
               r_rdata <= '0;
            end
         endcase
      end
   end

   assign w_in_req  = (r_state == S_REQ);
   assign w_in_resp = (r_state == S_RESP);

   assign req_ready_o = (r_state == S_IDLE);
   assign rsp_valid_o = w_in_resp;
   assign rsp_err_o   = w_in_resp & r_err;
   assign rdata_o     = w_in_resp ? r_rdata : 32'd0;

   assign mem_req_o   = w_in_req;
   assign mem_we_o    = w_in_req & r_req.we;
   assign mem_addr_o  = w_in_req ? {r_req.addr[31:2], 2'b00} : 32'd0;
   assign mem_be_o    = w_in_req ? w_be : 4'd0;
   assign mem_wdata_o = (w_in_req && r_req.we) ? w_wdata : 32'd0;

endmodule
